// File: rtl/bcd_to_bin_pkg.sv
// rtl/bcd_to_bin_pkg.sv - shared constants and state encoding for the BCD/binary converters
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int          BCD_DIGITS   = 3;
  localparam logic [7:0]  BIN_MAX      = 8'd255;
  localparam int          ITER_DEFAULT = 10;

endpackage

// File: rtl/bcd_to_bin_if.sv
// rtl/bcd_to_bin_if.sv - request/result bundle between digit entry and the converter
interface bcd_to_bin_if;
  logic       start;
  logic [3:0] cent;
  logic [3:0] dec;
  logic [3:0] uni;
  logic       busy;
  logic       done;
  logic [7:0] bin;
  logic       ovf;
  logic       err;

  modport master (
    output start, cent, dec, uni,
    input  busy, done, bin, ovf, err
  );

  modport slave (
    input  start, cent, dec, uni,
    output busy, done, bin, ovf, err
  );
endinterface

// File: rtl/bcd_to_bin_digit_adj.sv
// rtl/bcd_to_bin_digit_adj.sv - per-digit dabble correction
// ADD3=0: reverse direction (>=8 -> -3); ADD3=1: forward direction (>=5 -> +3).
module bcd_digit_adj #(
  parameter bit ADD3 = 1'b0
) (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = ADD3 ? ((i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit)
                        : ((i_digit >= 4'd8) ? i_digit - 4'd3 : i_digit);

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter, one reverse double-dabble step per clock
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_to_bin_if.slave  bus
);

  localparam int SR_W = 4 * BCD_DIGITS + ITER;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SR_W-1:0]   r_sr;
  logic [3:0]        r_cnt;
  logic              r_done;
  logic              r_ovf;
  logic              r_err;
  logic [7:0]        r_bin;

  logic [SR_W-1:0]   w_shift;
  logic [SR_W-1:0]   w_step;
  logic [ITER-1:0]   w_result;
  logic              w_last;
  logic              w_digit_bad;

  assign w_shift = r_sr >> 1;

  // The accumulator bits pass through; only the digit fields get corrected.
  assign w_step[ITER-1:0] = w_shift[ITER-1:0];
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj #(.ADD3(1'b0)) u_adj (
      .i_digit (w_shift[ITER + 4*g +: 4]),
      .o_digit (w_step [ITER + 4*g +: 4])
    );
  end

  assign w_result    = w_step[ITER-1:0];
  assign w_last      = (r_cnt == 4'(ITER - 1));
  assign w_digit_bad = (bus.cent > 4'd9) || (bus.dec > 4'd9) || (bus.uni > 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start && !w_digit_bad) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_bin  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_digit_bad) begin
              r_err  <= 1'b1;
              r_ovf  <= 1'b0;
              r_bin  <= 8'h00;
              r_done <= 1'b1;
            end else begin
              r_sr  <= {bus.cent, bus.dec, bus.uni, {ITER{1'b0}}};
              r_cnt <= '0;
            end
          end
        end
        SHIFT: begin
          r_sr  <= w_step;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_ovf  <= (w_result > ITER'(BIN_MAX));
            r_bin  <= (w_result > ITER'(BIN_MAX)) ? 8'hFF : w_result[7:0];
            r_err  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = r_done;
  assign bus.bin  = r_bin;
  assign bus.ovf  = r_ovf;
  assign bus.err  = r_err;

endmodule
